// File: rtl/periph_bus_arbiter.sv
// Two-master sequencer for the shared 16-bit peripheral bus: fixed-priority arbitration
// with m1 starvation relief, region decode, per-region wait states and one-cycle acks.
module periph_bus_arbiter #(
  parameter int unsigned WAIT_RAM   = 0,
  parameter int unsigned WAIT_IO    = 2,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [15:0] m0_addr,
  input  logic [15:0] m0_wdata,
  output logic        m0_ack,
  output logic [15:0] m0_rdata,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [15:0] m1_addr,
  input  logic [15:0] m1_wdata,
  output logic        m1_ack,
  output logic [15:0] m1_rdata,
  output logic [15:0] bus_addr,
  output logic [15:0] bus_wdata,
  input  logic [15:0] bus_rdata,
  output logic        bus_read,
  output logic        bus_write,
  output logic        cs_ram,
  output logic        cs_audio,
  output logic        cs_graphics,
  output logic        cs_spart,
  output logic        cs_ps2,
  output logic        grant_m1,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  localparam logic [3:0] WAIT_RAM_C   = 4'(WAIT_RAM);
  localparam logic [3:0] WAIT_IO_C    = 4'(WAIT_IO);
  localparam logic [3:0] STARVE_MAX_C = 4'(STARVE_MAX);

  state_e      state_q, state_d;
  logic        owner_q, owner_d;
  logic        we_q, we_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic [3:0]  wait_q, wait_d;
  logic [3:0]  starve_q, starve_d;
  logic [15:0] m0_rdata_q, m0_rdata_d;
  logic [15:0] m1_rdata_q, m1_rdata_d;

  // Arbitration result, only acted upon in IDLE.
  logic        pick_m1;
  logic        any_req;
  logic        both_req;
  logic [15:0] sel_addr;
  logic [15:0] sel_wdata;
  logic        sel_we;
  logic        sel_io;

  assign any_req   = m0_req | m1_req;
  assign both_req  = m0_req & m1_req;
  assign pick_m1   = m1_req & (~m0_req | (starve_q == STARVE_MAX_C));
  assign sel_addr  = pick_m1 ? m1_addr  : m0_addr;
  assign sel_wdata = pick_m1 ? m1_wdata : m0_wdata;
  assign sel_we    = pick_m1 ? m1_we    : m0_we;
  assign sel_io    = (sel_addr[15:12] >= 4'hC);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      owner_q    <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= 16'h0;
      wdata_q    <= 16'h0;
      wait_q     <= 4'h0;
      starve_q   <= 4'h0;
      m0_rdata_q <= 16'h0;
      m1_rdata_q <= 16'h0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      wait_q     <= wait_d;
      starve_q   <= starve_d;
      m0_rdata_q <= m0_rdata_d;
      m1_rdata_q <= m1_rdata_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    wait_d     = wait_q;
    starve_d   = starve_q;
    m0_rdata_d = m0_rdata_q;
    m1_rdata_d = m1_rdata_q;

    case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          owner_d = pick_m1;
          addr_d  = sel_addr;
          wdata_d = sel_wdata;
          we_d    = sel_we;
          wait_d  = sel_io ? WAIT_IO_C : WAIT_RAM_C;
          state_d = ST_ACCESS;
          // Starvation count only moves when both masters actually contend.
          if (pick_m1) begin
            starve_d = 4'h0;
          end else if (both_req && (starve_q != STARVE_MAX_C)) begin
            starve_d = starve_q + 4'h1;
          end
        end
      end
      ST_ACCESS: begin
        if (wait_q == 4'h0) begin
          state_d = ST_DONE;
          if (!we_q) begin
            if (owner_q) m1_rdata_d = bus_rdata;
            else         m0_rdata_d = bus_rdata;
          end
        end else begin
          wait_d = wait_q - 4'h1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Bus-side outputs decode straight from state so an async reset removes them immediately.
  logic in_access;
  logic in_done;
  assign in_access = (state_q == ST_ACCESS);
  assign in_done   = (state_q == ST_DONE);

  assign cs_ram      = in_access & (addr_q[15:12] <  4'hC);
  assign cs_audio    = in_access & (addr_q[15:12] == 4'hC);
  assign cs_graphics = in_access & (addr_q[15:12] == 4'hD);
  assign cs_spart    = in_access & (addr_q[15:12] == 4'hE);
  assign cs_ps2      = in_access & (addr_q[15:12] == 4'hF);
  assign bus_read    = in_access & ~we_q;
  assign bus_write   = in_access &  we_q;
  assign bus_addr    = addr_q;
  assign bus_wdata   = wdata_q;

  assign m0_ack    = in_done & ~owner_q;
  assign m1_ack    = in_done &  owner_q;
  assign m0_rdata  = m0_rdata_q;
  assign m1_rdata  = m1_rdata_q;
  assign grant_m1  = owner_q & (state_q != ST_IDLE);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_periph_bus_arbiter.sv
// Directed bench for periph_bus_arbiter: timing, decode, starvation relief,
// mid-access reset and a master abandoning its request.
module tb_periph_bus_arbiter;

  logic        clk;
  logic        rst;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [15:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic        m0_ack, m1_ack;
  logic [15:0] m0_rdata, m1_rdata;
  logic [15:0] bus_addr, bus_wdata, bus_rdata;
  logic        bus_read, bus_write;
  logic        cs_ram, cs_audio, cs_graphics, cs_spart, cs_ps2;
  logic        grant_m1;
  logic [1:0]  dbg_state;

  int errors = 0;
  int checks = 0;

  // {cs_ram,cs_audio,cs_graphics,cs_spart,cs_ps2,bus_read,bus_write,m0_ack,m1_ack,grant_m1}
  logic [9:0] ctl;
  assign ctl = {cs_ram, cs_audio, cs_graphics, cs_spart, cs_ps2,
                bus_read, bus_write, m0_ack, m1_ack, grant_m1};

  periph_bus_arbiter #(.WAIT_RAM(0), .WAIT_IO(2), .STARVE_MAX(4)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_ack(m0_ack), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_ack(m1_ack), .m1_rdata(m1_rdata),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata),
    .bus_read(bus_read), .bus_write(bus_write),
    .cs_ram(cs_ram), .cs_audio(cs_audio), .cs_graphics(cs_graphics),
    .cs_spart(cs_spart), .cs_ps2(cs_ps2),
    .grant_m1(grant_m1), .dbg_state(dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no summary, required completion");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    m0_req = 0; m0_we = 0; m0_addr = 16'h0; m0_wdata = 16'h0;
    m1_req = 0; m1_we = 0; m1_addr = 16'h0; m1_wdata = 16'h0;
    bus_rdata = 16'h0;
    repeat (2) @(negedge clk);
    checks++; if (ctl !== 10'b0) begin errors++; $display("FAIL reset_ctl got=%b exp=%b", ctl, 10'b0); end
    checks++; if (dbg_state !== 2'd0) begin errors++; $display("FAIL reset_state got=%0d exp=0", dbg_state); end
    checks++; if (bus_addr !== 16'h0 || bus_wdata !== 16'h0) begin errors++; $display("FAIL reset_bus got=%h/%h exp=0000/0000", bus_addr, bus_wdata); end
    checks++; if (m0_rdata !== 16'h0 || m1_rdata !== 16'h0) begin errors++; $display("FAIL reset_rdata got=%h/%h exp=0000/0000", m0_rdata, m1_rdata); end
    rst = 1'b1;
    step();
    checks++; if (dbg_state !== 2'd0 || ctl !== 10'b0) begin errors++; $display("FAIL reset_release got=%0d/%b exp=0/%b", dbg_state, ctl, 10'b0); end
  endtask

  task automatic test_ram_read();
    bus_rdata = 16'hBEEF;
    m0_we = 0; m0_addr = 16'h1234; m0_req = 1;
    step();
    checks++; if (ctl !== 10'b10000_10000) begin errors++; $display("FAIL ram_read_access got=%b exp=%b", ctl, 10'b10000_10000); end
    checks++; if (bus_addr !== 16'h1234) begin errors++; $display("FAIL ram_read_addr got=%h exp=1234", bus_addr); end
    step();
    checks++; if (ctl !== 10'b00000_00100) begin errors++; $display("FAIL ram_read_ack got=%b exp=%b", ctl, 10'b00000_00100); end
    checks++; if (m0_rdata !== 16'hBEEF) begin errors++; $display("FAIL ram_read_data got=%h exp=beef", m0_rdata); end
    m0_req = 0;
    step();
    checks++; if (ctl !== 10'b0 || dbg_state !== 2'd0) begin errors++; $display("FAIL ram_read_idle got=%b/%0d exp=%b/0", ctl, dbg_state, 10'b0); end
  endtask

  task automatic test_io_write();
    m0_we = 1; m0_addr = 16'hD003; m0_wdata = 16'h00FF; m0_req = 1;
    step();
    m0_addr = 16'h0000; m0_wdata = 16'h1111;
    for (int i = 0; i < 3; i++) begin
      checks++; if (ctl !== 10'b00100_01000) begin errors++; $display("FAIL io_write_access%0d got=%b exp=%b", i, ctl, 10'b00100_01000); end
      checks++; if (bus_wdata !== 16'h00FF || bus_addr !== 16'hD003) begin errors++; $display("FAIL io_write_bus%0d got=%h/%h exp=d003/00ff", i, bus_addr, bus_wdata); end
      step();
    end
    checks++; if (ctl !== 10'b00000_00100) begin errors++; $display("FAIL io_write_ack got=%b exp=%b", ctl, 10'b00000_00100); end
    m0_req = 0; m0_we = 0;
    step();
    checks++; if (ctl !== 10'b0) begin errors++; $display("FAIL io_write_idle got=%b exp=%b", ctl, 10'b0); end
  endtask

  task automatic test_decode();
    logic [15:0] addrs [5];
    logic [4:0]  exp_cs [5];
    int n;
    addrs[0] = 16'hC000; exp_cs[0] = 5'b01000;
    addrs[1] = 16'hD000; exp_cs[1] = 5'b00100;
    addrs[2] = 16'hE000; exp_cs[2] = 5'b00010;
    addrs[3] = 16'hF000; exp_cs[3] = 5'b00001;
    addrs[4] = 16'hB000; exp_cs[4] = 5'b10000;
    for (int i = 0; i < 5; i++) begin
      m0_we = 0; m0_addr = addrs[i]; m0_req = 1;
      step();
      checks++; if (ctl[9:5] !== exp_cs[i] || bus_read !== 1'b1) begin errors++; $display("FAIL decode_%h got=%b rd=%b exp=%b rd=1", addrs[i], ctl[9:5], bus_read, exp_cs[i]); end
      n = 0;
      while (!m0_ack && n < 10) begin step(); n++; end
      checks++; if (m0_ack !== 1'b1) begin errors++; $display("FAIL decode_ack_%h got=%b exp=1", addrs[i], m0_ack); end
      m0_req = 0;
      step();
    end
  endtask

  // Both masters request continuously; bit i of exp_m1 says whether ack i belongs to m1.
  task automatic run_contention(input string tag, input int total, input logic [15:0] exp_m1);
    int got;
    int cyc;
    logic [15:0] mask;
    mask = exp_m1;
    got = 0; cyc = 0;
    m0_we = 0; m0_addr = 16'h0010; m0_req = 1;
    m1_we = 0; m1_addr = 16'h0020; m1_req = 1;
    while (got < total && cyc < 100) begin
      step();
      cyc++;
      checks++;
      if (m0_ack && m1_ack) begin
        errors++; $display("FAIL %s_ack_overlap got=11 exp=one-hot", tag);
      end else if (m0_ack || m1_ack) begin
        checks++;
        if (m1_ack !== mask[got] || grant_m1 !== mask[got]) begin
          errors++; $display("FAIL %s_grant%0d got=m1_ack:%b grant:%b exp=%b", tag, got, m1_ack, grant_m1, mask[got]);
        end
        got++;
        if (got == total) begin m0_req = 0; m1_req = 0; end
      end
    end
    checks++; if (got != total) begin errors++; $display("FAIL %s_timeout got=%0d exp=%0d acks", tag, got, total); end
    m0_req = 0; m1_req = 0;
    step();
  endtask

  task automatic test_starve();
    bus_rdata = 16'h1357;
    run_contention("starve", 10, 16'h0210);
  endtask

  task automatic test_reset_mid();
    run_contention("pre_reset", 2, 16'h0000);
    m0_we = 1; m0_addr = 16'hE010; m0_wdata = 16'hABCD; m0_req = 1;
    step();
    step();
    checks++; if (ctl !== 10'b00010_01000) begin errors++; $display("FAIL rst_mid_access got=%b exp=%b", ctl, 10'b00010_01000); end
    rst = 1'b0; m0_req = 0; m0_we = 0;
    #1;
    checks++; if (ctl !== 10'b0 || dbg_state !== 2'd0) begin errors++; $display("FAIL rst_mid_drop got=%b/%0d exp=%b/0", ctl, dbg_state, 10'b0); end
    checks++; if (bus_addr !== 16'h0 || bus_wdata !== 16'h0) begin errors++; $display("FAIL rst_mid_bus got=%h/%h exp=0000/0000", bus_addr, bus_wdata); end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++; if (ctl !== 10'b0) begin errors++; $display("FAIL rst_mid_hold%0d got=%b exp=%b", i, ctl, 10'b0); end
    end
    rst = 1'b1;
    step();
    checks++; if (ctl !== 10'b0 || dbg_state !== 2'd0) begin errors++; $display("FAIL rst_mid_release got=%b/%0d exp=%b/0", ctl, dbg_state, 10'b0); end
    run_contention("post_reset", 5, 16'h0010);
  endtask

  task automatic test_m1_drop();
    bus_rdata = 16'h5A5A;
    m1_we = 0; m1_addr = 16'hC004; m1_req = 1;
    step();
    checks++; if (ctl !== 10'b01000_10001) begin errors++; $display("FAIL m1_drop_access got=%b exp=%b", ctl, 10'b01000_10001); end
    m1_req = 0;
    m0_we = 0; m0_addr = 16'h0300; m0_req = 1;
    step();
    step();
    checks++; if (ctl !== 10'b01000_10001 || bus_addr !== 16'hC004) begin errors++; $display("FAIL m1_drop_hold got=%b/%h exp=%b/c004", ctl, bus_addr, 10'b01000_10001); end
    step();
    checks++; if (ctl !== 10'b00000_00011) begin errors++; $display("FAIL m1_drop_ack got=%b exp=%b", ctl, 10'b00000_00011); end
    checks++; if (m1_rdata !== 16'h5A5A) begin errors++; $display("FAIL m1_drop_data got=%h exp=5a5a", m1_rdata); end
    step();
    checks++; if (ctl !== 10'b0) begin errors++; $display("FAIL m1_drop_idle got=%b exp=%b", ctl, 10'b0); end
    bus_rdata = 16'h2468;
    step();
    checks++; if (ctl !== 10'b10000_10000 || bus_addr !== 16'h0300) begin errors++; $display("FAIL m1_drop_m0_access got=%b/%h exp=%b/0300", ctl, bus_addr, 10'b10000_10000); end
    step();
    checks++; if (ctl !== 10'b00000_00100 || m0_rdata !== 16'h2468) begin errors++; $display("FAIL m1_drop_m0_ack got=%b/%h exp=%b/2468", ctl, m0_rdata, 10'b00000_00100); end
    checks++; if (m1_rdata !== 16'h5A5A) begin errors++; $display("FAIL m1_drop_m1_hold got=%h exp=5a5a", m1_rdata); end
    m0_req = 0;
    step();
  endtask

  initial begin
    test_reset();
    test_ram_read();
    test_io_write();
    test_decode();
    test_starve();
    test_reset_mid();
    test_m1_drop();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
